// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART with configurable frame format and a small RX FIFO.
// TX serialises bytes accepted over a ready/valid handshake; RX deserialises
// mid-bit samples, checks parity/stop and queues {parity_err, data} entries.
module uart_cfg #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 serial_tx,
  input  logic [DATA_BITS-1:0] tx_byte,
  input  logic                 tx_valid,
  output logic                 tx_ready
);

  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int AW    = $clog2(RX_FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // ---------------- TX state ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 serial_tx_q, serial_tx_d;
  logic                 tx_ready_q, tx_ready_d;

  // ---------------- RX state ----------------
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_push;

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS:0]   fifo_mem_q [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 fifo_empty, fifo_full, rx_pop;
  logic [DATA_BITS:0]   fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rx_pop     = !fifo_empty && rx_ready;
  assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  assign rx_byte       = fifo_head[DATA_BITS-1:0];
  assign rx_parity_err = fifo_head[DATA_BITS];
  assign rx_valid      = !fifo_empty;
  assign rx_frame_err  = frame_err_q;
  assign rx_overrun    = overrun_q;
  assign serial_tx     = serial_tx_q;
  assign tx_ready      = tx_ready_q;

  // TX next-state: the line level for each bit is decided one cycle ahead so serial_tx is a flop
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + CNT_W'(1);
    tx_idx_d    = tx_idx_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    serial_tx_d = serial_tx_q;
    tx_ready_d  = tx_ready_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_valid && tx_ready_q) begin
          tx_state_d  = TX_START;
          serial_tx_d = 1'b0;
          tx_ready_d  = 1'b0;
          tx_shift_d  = tx_byte;
          tx_par_d    = (PARITY == 1) ? ~^tx_byte : ^tx_byte;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d    = '0;
          tx_state_d  = TX_DATA;
          tx_idx_d    = '0;
          serial_tx_d = tx_shift_q[0];
          tx_shift_d  = tx_shift_q >> 1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LAST_IDX) begin
            if (PARITY != 0) begin
              tx_state_d  = TX_PARITY;
              serial_tx_d = tx_par_q;
            end else begin
              tx_state_d  = TX_STOP;
              serial_tx_d = 1'b1;
            end
          end else begin
            tx_idx_d    = tx_idx_q + IDX_W'(1);
            serial_tx_d = tx_shift_q[0];
            tx_shift_d  = tx_shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d    = '0;
          tx_state_d  = TX_STOP;
          serial_tx_d = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == STOP_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_ready_d = 1'b1;
        end
      end
      default: begin
        tx_state_d  = TX_IDLE;
        serial_tx_d = 1'b1;
        tx_ready_d  = 1'b1;
      end
    endcase
  end

  // RX next-state: counts to mid-bit then samples; a full FIFO drops the frame unless a pop frees a slot
  always_comb begin
    rx_meta_d   = serial_rx;
    rx_sync_d   = rx_meta_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + CNT_W'(1);
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_perr_d   = rx_perr_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    rx_push     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_idx_d   = '0;
            rx_perr_d  = 1'b0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == LAST_IDX) begin
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_STOP;
          rx_perr_d  = (rx_sync_q != ((PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q));
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end else begin
            rx_state_d = RX_IDLE;
            if (fifo_full && !rx_pop) overrun_d = 1'b1;
            else                      rx_push   = 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO pointer update: push and pop are independent so a simultaneous pair keeps the count
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(rx_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(rx_pop);
  end

  // All state registers; reset aborts any frame in flight and empties the FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      serial_tx_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
      rx_perr_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      serial_tx_q <= serial_tx_d;
      tx_ready_q  <= tx_ready_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      rx_perr_q   <= rx_perr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (rx_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {rx_perr_q, rx_shift_q};
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: three instances cover 8N1, 8O1 and 7E2 framing.
module tb_uart_cfg;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // Instance a: defaults (8N1)
  logic       serial_rx_a = 1'b1, serial_tx_a, rx_parity_err_a, rx_valid_a, rx_ready_a = 1'b0;
  logic       rx_frame_err_a, rx_overrun_a, tx_valid_a = 1'b0, tx_ready_a;
  logic [7:0] rx_byte_a, tx_byte_a = 8'h00;
  // Instance b: odd parity
  logic       serial_rx_b = 1'b1, serial_tx_b, rx_parity_err_b, rx_valid_b, rx_ready_b = 1'b0;
  logic       rx_frame_err_b, rx_overrun_b, tx_valid_b = 1'b0, tx_ready_b;
  logic [7:0] rx_byte_b, tx_byte_b = 8'h00;
  // Instance c: 7 data bits, even parity, 2 stop bits
  logic       serial_rx_c = 1'b1, serial_tx_c, rx_parity_err_c, rx_valid_c, rx_ready_c = 1'b0;
  logic       rx_frame_err_c, rx_overrun_c, tx_valid_c = 1'b0, tx_ready_c;
  logic [6:0] rx_byte_c, tx_byte_c = 7'h00;

  uart_cfg dut_a (
    .clock(clock), .reset(reset), .serial_rx(serial_rx_a), .rx_byte(rx_byte_a),
    .rx_parity_err(rx_parity_err_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_frame_err(rx_frame_err_a), .rx_overrun(rx_overrun_a), .serial_tx(serial_tx_a),
    .tx_byte(tx_byte_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a)
  );

  uart_cfg #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .serial_rx(serial_rx_b), .rx_byte(rx_byte_b),
    .rx_parity_err(rx_parity_err_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_frame_err(rx_frame_err_b), .rx_overrun(rx_overrun_b), .serial_tx(serial_tx_b),
    .tx_byte(tx_byte_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b)
  );

  uart_cfg #(.CLKS_PER_BIT(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dut_c (
    .clock(clock), .reset(reset), .serial_rx(serial_rx_c), .rx_byte(rx_byte_c),
    .rx_parity_err(rx_parity_err_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c),
    .rx_frame_err(rx_frame_err_c), .rx_overrun(rx_overrun_c), .serial_tx(serial_tx_c),
    .tx_byte(tx_byte_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Pulse counters so sequences can check how many one-cycle error pulses happened
  int ferr_cnt [3] = '{0, 0, 0};
  int ovr_cnt  [3] = '{0, 0, 0};

  // Count frame-error and overrun pulses on every instance
  always @(negedge clock) begin
    if (rx_frame_err_a) ferr_cnt[0] <= ferr_cnt[0] + 1;
    if (rx_frame_err_b) ferr_cnt[1] <= ferr_cnt[1] + 1;
    if (rx_frame_err_c) ferr_cnt[2] <= ferr_cnt[2] + 1;
    if (rx_overrun_a)   ovr_cnt[0]  <= ovr_cnt[0] + 1;
    if (rx_overrun_b)   ovr_cnt[1]  <= ovr_cnt[1] + 1;
    if (rx_overrun_c)   ovr_cnt[2]  <= ovr_cnt[2] + 1;
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] slots;   // expected line level per bit slot, slot 0 = start bit
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;      // parity bit placed on the line
    logic       stop;
    logic       exp_push;
    logic       exp_perr;
    int         exp_ferr;
  } rx_vec_t;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0: return serial_tx_a;
      1: return serial_tx_b;
      default: return serial_tx_c;
    endcase
  endfunction

  function automatic logic get_txr(input int sel);
    case (sel)
      0: return tx_ready_a;
      1: return tx_ready_b;
      default: return tx_ready_c;
    endcase
  endfunction

  task automatic apply_stimulus(input int sel, input logic [7:0] data, input logic valid);
    case (sel)
      0: begin tx_byte_a = data; tx_valid_a = valid; end
      1: begin tx_byte_b = data; tx_valid_b = valid; end
      default: begin tx_byte_c = data[6:0]; tx_valid_c = valid; end
    endcase
  endtask

  task automatic drive_rx(input int sel, input logic val);
    case (sel)
      0: serial_rx_a = val;
      1: serial_rx_b = val;
      default: serial_rx_c = val;
    endcase
  endtask

  // Drive one frame, 10 cycles per bit, followed by a short idle-high gap
  task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                            input bit has_par, input logic par, input logic stop);
    drive_rx(sel, 1'b0);
    repeat (10) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      drive_rx(sel, data[i]);
      repeat (10) @(negedge clock);
    end
    if (has_par) begin
      drive_rx(sel, par);
      repeat (10) @(negedge clock);
    end
    drive_rx(sel, stop);
    repeat (10) @(negedge clock);
    drive_rx(sel, 1'b1);
    repeat (8) @(negedge clock);
  endtask

  task automatic pop_rx(input int sel);
    if (sel == 0) rx_ready_a = 1'b1; else rx_ready_b = 1'b1;
    @(negedge clock);
    rx_ready_a = 1'b0;
    rx_ready_b = 1'b0;
  endtask

  // Send one byte and check every cycle of every bit slot plus tx_ready behaviour
  task automatic tx_frame_check(input int sel, input logic [7:0] data, input logic [15:0] slots,
                                input int nslots, input string tag);
    logic [9:0] seen;
    int busy;
    busy = 0;
    apply_stimulus(sel, data, 1'b1);
    @(negedge clock);
    apply_stimulus(sel, data, 1'b0);
    for (int s = 0; s < nslots; s++) begin
      for (int c = 0; c < 10; c++) begin
        seen[c] = get_tx(sel);
        if (get_txr(sel)) busy++;
        @(negedge clock);
      end
      check_output($sformatf("%s slot %0d", tag, s), 32'(seen), slots[s] ? 32'h3FF : 32'h0);
    end
    check_output({tag, " tx_ready high cycles in frame"}, 32'(busy), 32'd0);
    check_output({tag, " tx_ready after frame"}, 32'(get_txr(sel)), 32'd1);
    check_output({tag, " line idle after frame"}, 32'(get_tx(sel)), 32'd1);
  endtask

  tx_vec_t    tx_tab [5];
  rx_vec_t    rx_tab [6];
  logic [7:0] b2b_bytes [5];
  logic [7:0] ovr_bytes [4];

  initial begin
    int f0, o0, acc, pend, active, cnt, first_cyc, last_cyc;
    logic [7:0] dec;
    logic [7:0] got [$];
    logic [7:0] g;

    tx_tab[0] = '{8'h55, 16'b1010101010};
    tx_tab[1] = '{8'hA3, 16'b1101000110};
    tx_tab[2] = '{8'h00, 16'b1000000000};
    tx_tab[3] = '{8'hFF, 16'b1111111110};
    tx_tab[4] = '{8'h81, 16'b1100000010};

    rx_tab[0] = '{8'hAC, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    rx_tab[1] = '{8'hAC, 1'b0, 1'b1, 1'b1, 1'b1, 0};
    rx_tab[2] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    rx_tab[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 0};
    rx_tab[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    rx_tab[5] = '{8'h37, 1'b0, 1'b1, 1'b1, 1'b0, 0};

    b2b_bytes = '{8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
    ovr_bytes = '{8'hAC, 8'hAD, 8'hAE, 8'hAF};

    // Reset values
    repeat (3) @(negedge clock);
    check_output("reset serial_tx", 32'(serial_tx_a), 32'd1);
    check_output("reset tx_ready", 32'(tx_ready_a), 32'd1);
    check_output("reset rx_valid", 32'(rx_valid_a), 32'd0);
    check_output("reset rx_byte", 32'(rx_byte_a), 32'd0);
    check_output("reset rx_parity_err", 32'(rx_parity_err_a), 32'd0);
    check_output("reset err pulses", 32'({rx_frame_err_a, rx_overrun_a}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // TX 8N1 frames from the table
    for (int i = 0; i < 5; i++) begin
      tx_frame_check(0, tx_tab[i].data, tx_tab[i].slots, 10, $sformatf("tx8n1[%0d]", i));
      @(negedge clock);
    end

    // TX 7E2 frame: 0x2C -> data 0,0,1,1,0,1,0, parity 1, two stop slots
    tx_frame_check(2, 8'h2C, 16'b11101011000, 11, "tx7e2");

    // Back-to-back TX with tx_valid held, decoded by a mid-bit sampler
    acc = 0; pend = 0; active = 0; cnt = 0; dec = 8'h00; first_cyc = -1; last_cyc = -1;
    @(negedge clock);
    apply_stimulus(0, b2b_bytes[0], 1'b1);
    for (int cyc = 0; cyc < 560; cyc++) begin
      if (active != 0) begin
        cnt++;
        if (cnt >= 15 && cnt <= 85 && (cnt % 10) == 5) dec = {serial_tx_a, dec[7:1]};
        if (cnt == 100) begin
          got.push_back(dec);
          active = 0;
          last_cyc = cyc;
        end
      end else if (serial_tx_a == 1'b0) begin
        active = 1;
        cnt = 1;
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (pend != 0) begin
        pend = 0;
        if (acc < 5) apply_stimulus(0, b2b_bytes[acc], 1'b1);
        else         apply_stimulus(0, 8'h00, 1'b0);
      end
      if (tx_valid_a && tx_ready_a) begin
        acc++;
        pend = 1;
      end
      @(negedge clock);
    end
    apply_stimulus(0, 8'h00, 1'b0);
    check_output("b2b accepted count", 32'(acc), 32'd5);
    check_output("b2b frame count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      g = (i < got.size()) ? got[i] : 8'h00;
      check_output($sformatf("b2b byte %0d", i), 32'(g), 32'(b2b_bytes[i]));
    end
    check_output("b2b span 500..504", 32'((last_cyc - first_cyc + 1) >= 500 &&
                                          (last_cyc - first_cyc + 1) <= 504), 32'd1);

    // RX fill with rx_ready low: four queue, fifth overruns
    o0 = ovr_cnt[0];
    for (int i = 0; i < 4; i++) send_frame(0, ovr_bytes[i], 8, 1'b0, 1'b0, 1'b1);
    check_output("rx fill no overrun", 32'(ovr_cnt[0] - o0), 32'd0);
    check_output("rx fill valid", 32'(rx_valid_a), 32'd1);
    send_frame(0, 8'hB0, 8, 1'b0, 1'b0, 1'b1);
    check_output("rx overrun pulse", 32'(ovr_cnt[0] - o0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("rx pop %0d byte", i), 32'(rx_byte_a), 32'(ovr_bytes[i]));
      check_output($sformatf("rx pop %0d valid", i), 32'(rx_valid_a), 32'd1);
      pop_rx(0);
    end
    check_output("rx drained", 32'(rx_valid_a), 32'd0);

    // RX odd-parity table on instance b
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt[1];
      send_frame(1, rx_tab[i].data, 8, 1'b1, rx_tab[i].par, rx_tab[i].stop);
      check_output($sformatf("rxtab[%0d] frame_err", i), 32'(ferr_cnt[1] - f0), 32'(rx_tab[i].exp_ferr));
      check_output($sformatf("rxtab[%0d] valid", i), 32'(rx_valid_b), 32'(rx_tab[i].exp_push));
      if (rx_tab[i].exp_push) begin
        check_output($sformatf("rxtab[%0d] byte", i), 32'(rx_byte_b), 32'(rx_tab[i].data));
        check_output($sformatf("rxtab[%0d] parity_err", i), 32'(rx_parity_err_b), 32'(rx_tab[i].exp_perr));
        pop_rx(1);
      end
    end

    // Stop bit low on 8N1: one frame-error pulse, nothing queued
    f0 = ferr_cnt[0];
    send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
    check_output("stop low frame_err", 32'(ferr_cnt[0] - f0), 32'd1);
    check_output("stop low no push", 32'(rx_valid_a), 32'd0);

    // Three-cycle glitch: no error, no data, and RX still receives afterwards
    f0 = ferr_cnt[0];
    drive_rx(0, 1'b0);
    repeat (3) @(negedge clock);
    drive_rx(0, 1'b1);
    repeat (120) @(negedge clock);
    check_output("glitch frame_err", 32'(ferr_cnt[0] - f0), 32'd0);
    check_output("glitch no push", 32'(rx_valid_a), 32'd0);
    send_frame(0, 8'h4B, 8, 1'b0, 1'b0, 1'b1);
    check_output("after glitch byte", 32'(rx_byte_a), 32'h4B);
    check_output("after glitch valid", 32'(rx_valid_a), 32'd1);
    pop_rx(0);

    // Reset mid-RX frame: nothing may reach the FIFO
    f0 = ferr_cnt[0];
    drive_rx(0, 1'b0);
    repeat (35) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    drive_rx(0, 1'b1);
    reset = 1'b0;
    repeat (120) @(negedge clock);
    check_output("rx reset mid-frame valid", 32'(rx_valid_a), 32'd0);
    check_output("rx reset mid-frame frame_err", 32'(ferr_cnt[0] - f0), 32'd0);

    // Reset mid-TX frame: line returns high and TX is ready at once
    apply_stimulus(0, 8'h00, 1'b1);
    @(negedge clock);
    apply_stimulus(0, 8'h00, 1'b0);
    repeat (25) @(negedge clock);
    check_output("tx mid-frame line low", 32'(serial_tx_a), 32'd0);
    reset = 1'b1;
    #1;
    check_output("tx reset line high", 32'(serial_tx_a), 32'd1);
    check_output("tx reset ready", 32'(tx_ready_a), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (120) @(negedge clock);
    check_output("tx after reset idle", 32'(serial_tx_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
